// File: rtl/mux_scan_sequencer.sv
// Select sequencer for the N:1 mux: walks enabled channels in ascending order, dwelling on each.
// Build option MUX_SCAN_ONESHOT_EN: stop after one sweep instead of scanning continuously.
module mux_scan_sequencer #(
  parameter  int NUM_CH       = 2,
  parameter  int DWELL_CYCLES = 4,
  localparam int SEL_W        = $clog2(NUM_CH),
  localparam int CNT_W        = $clog2(DWELL_CYCLES) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [NUM_CH-1:0] i_ch_mask,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_busy,
  output logic              o_strobe,
  output logic              o_wrap
);

  typedef enum logic {IDLE, DWELL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   nxt_q, nxt_d;
  logic               wrap_q, wrap_d;
  logic               last_q, last_d;
  logic [SEL_W:0]     hit;
  logic               strobe;

  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) r = SEL_W'(i);
    return r;
  endfunction

  // {found, index} of the lowest enabled channel strictly above s
  function automatic logic [SEL_W:0] above(input logic [SEL_W-1:0] s,
                                           input logic [NUM_CH-1:0] m);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(s))) r = {1'b1, SEL_W'(i)};
    return r;
  endfunction

  assign strobe   = (state_q == DWELL) && (cnt_q == CNT_LAST);
  assign o_busy   = (state_q == DWELL);
  assign o_sel    = sel_q;
  assign o_strobe = strobe;
  assign o_wrap   = strobe & wrap_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    nxt_d   = nxt_q;
    wrap_d  = wrap_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop && (|i_ch_mask)) begin
          state_d = DWELL;
          sel_d   = lowest(i_ch_mask);
          cnt_d   = '0;
        end
      end
      DWELL: begin
        if (i_stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (strobe) begin
          cnt_d = '0;
          if (last_q) state_d = IDLE;
          else        sel_d   = nxt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The mask is sampled on the edge entering a strobe cycle, so the advance
    // target and wrap flag are registered and the outputs never see i_ch_mask.
    hit = above(sel_d, i_ch_mask);
    if ((state_d == DWELL) && (cnt_d == CNT_LAST)) begin
      nxt_d  = hit[SEL_W] ? hit[SEL_W-1:0] : lowest(i_ch_mask);
      wrap_d = ~hit[SEL_W] & (|i_ch_mask);
`ifdef MUX_SCAN_ONESHOT_EN
      last_d = ~(|i_ch_mask) | ~hit[SEL_W];
`else
      last_d = ~(|i_ch_mask);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      nxt_q   <= '0;
      wrap_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      nxt_q   <= nxt_d;
      wrap_q  <= wrap_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboarded bench: main instance NUM_CH=4/DWELL_CYCLES=3, second instance NUM_CH=2/DWELL_CYCLES=1.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       a_start, a_stop, a_busy, a_strobe, a_wrap;
  logic [3:0] a_mask;
  logic [1:0] a_sel;
  logic       b_start, b_stop, b_busy, b_strobe, b_wrap;
  logic [1:0] b_mask;
  logic       b_sel;

  mux_scan_sequencer #(.NUM_CH(4), .DWELL_CYCLES(3)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_stop(a_stop), .i_ch_mask(a_mask),
    .o_sel(a_sel), .o_busy(a_busy), .o_strobe(a_strobe), .o_wrap(a_wrap));

  mux_scan_sequencer #(.NUM_CH(2), .DWELL_CYCLES(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_stop(b_stop), .i_ch_mask(b_mask),
    .o_sel(b_sel), .o_busy(b_busy), .o_strobe(b_strobe), .o_wrap(b_wrap));

  typedef struct {bit busy; int sel; int cnt; logic [15:0] pmask;} mdl_t;
  typedef struct {logic busy; logic strobe; logic wrap; logic [3:0] sel;} exp_t;

  exp_t qa[$], qb[$];
  mdl_t ma, mb;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int m_low(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int m_top(input logic [15:0] m);
    for (int i = 15; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  function automatic mdl_t m_idle();
    mdl_t r;
    r = '{busy: 1'b0, sel: 0, cnt: 0, pmask: '0};
    return r;
  endfunction

  // One rising edge of the reference model; pmask is the mask seen entering the strobe cycle.
  function automatic mdl_t mstep(input mdl_t s, input int nch, input int dw,
                                 input bit st, input bit sp, input logic [15:0] m);
    mdl_t n;
    n = s;
    if (!s.busy) begin
      if (st && !sp && (m != 0)) begin
        n.busy = 1'b1; n.cnt = 0; n.sel = m_low(m);
      end
    end else if (sp) begin
      n.busy = 1'b0; n.cnt = 0;
    end else if (s.cnt == dw - 1) begin
      n.cnt = 0;
      if ((s.pmask == 0) || (ONESHOT && (m_top(s.pmask) <= s.sel))) n.busy = 1'b0;
      else begin
        for (int j = 1; j <= nch; j++)
          if (s.pmask[(s.sel + j) % nch]) begin n.sel = (s.sel + j) % nch; break; end
      end
    end else begin
      n.cnt = s.cnt + 1;
    end
    if (n.busy && (n.cnt == dw - 1)) n.pmask = m;
    return n;
  endfunction

  function automatic exp_t mexp(input mdl_t s, input int dw);
    exp_t e;
    e.busy   = s.busy;
    e.strobe = s.busy && (s.cnt == dw - 1);
    e.wrap   = e.strobe && (s.pmask != 0) && (m_top(s.pmask) <= s.sel);
    e.sel    = 4'(s.sel);
    return e;
  endfunction

  task automatic cyc(input bit as, input bit ap, input logic [3:0] am,
                     input bit bs = 1'b0, input bit bp = 1'b0, input logic [1:0] bm = 2'b00);
    exp_t e;
    a_start = as; a_stop = ap; a_mask = am;
    b_start = bs; b_stop = bp; b_mask = bm;
    @(posedge clk);
    if (rst) begin
      ma = m_idle(); mb = m_idle();
    end else begin
      ma = mstep(ma, 4, 3, as, ap, {12'b0, am});
      mb = mstep(mb, 2, 1, bs, bp, {14'b0, bm});
    end
    qa.push_back(mexp(ma, 3));
    qb.push_back(mexp(mb, 1));
    @(negedge clk);
    e = qa.pop_front();
    chk("a_busy", a_busy, e.busy);   chk("a_sel", a_sel, e.sel);
    chk("a_strobe", a_strobe, e.strobe); chk("a_wrap", a_wrap, e.wrap);
    e = qb.pop_front();
    chk("b_busy", b_busy, e.busy);   chk("b_sel", b_sel, e.sel);
    chk("b_strobe", b_strobe, e.strobe); chk("b_wrap", b_wrap, e.wrap);
  endtask

  int sweep_sel [9] = '{0, 0, 0, 1, 1, 1, 3, 3, 3};
  int os_sel    [6] = '{1, 1, 1, 2, 2, 2};
  localparam int BN = ONESHOT ? 2 : 6;

  initial begin
    rst = 1'b1;
    ma = m_idle(); mb = m_idle();
    cyc(0, 0, 4'h0);
    cyc(0, 0, 4'h0);
    rst = 1'b0;
    chk("rst_sel", a_sel, 0); chk("rst_busy", a_busy, 0);
    chk("rst_strobe", a_strobe, 0); chk("rst_wrap", a_wrap, 0);

    // full sweep over channels 0,1,3
    for (int i = 0; i < 9; i++) begin
      cyc(i == 0, 0, 4'b1011);
      chk("sweep_sel", a_sel, sweep_sel[i]);
      chk("sweep_busy", a_busy, 1);
      chk("sweep_strobe", a_strobe, (i % 3) == 2);
      chk("sweep_wrap", a_wrap, i == 8);
    end
    cyc(0, 0, 4'b1011);
    cyc(0, 1, 4'b1011);
    cyc(0, 0, 4'b1011);

    // stop during the 2nd dwell cycle of channel 1
    cyc(1, 0, 4'b1011);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'b1011);
    cyc(0, 1, 4'b1011);
    chk("stop_busy", a_busy, 0); chk("stop_sel", a_sel, 1); chk("stop_strobe", a_strobe, 0);
    cyc(1, 1, 4'b1011);
    chk("startstop_busy", a_busy, 0);
    cyc(1, 0, 4'b0000);
    chk("nomask_busy", a_busy, 0);

    // mask narrows to channel 2 while channel 1 is dwelling, then goes empty
    cyc(1, 0, 4'b1111);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'b1111);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0100);
    chk("mask_ch2", a_sel, 2);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 4'b0100);
      chk("single_sel", a_sel, 2);
      chk("single_wrap", a_wrap, a_strobe);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'b0000);
    chk("empty_idle", a_busy, 0);

    // asynchronous reset between edges mid-dwell
    cyc(1, 0, 4'b1011);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'b1011);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", a_busy, 0); chk("arst_sel", a_sel, 0);
    chk("arst_strobe", a_strobe, 0); chk("arst_wrap", a_wrap, 0);
    cyc(0, 0, 4'b1011);
    rst = 1'b0;
    cyc(1, 0, 4'b1010);
    chk("restart_sel", a_sel, 1); chk("restart_busy", a_busy, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'b1010);
    cyc(0, 1, 4'b1010);

    // minimum dwell on the two-channel instance
    for (int i = 0; i < BN; i++) begin
      cyc(0, 0, 4'h0, i == 0, 0, 2'b11);
      chk("min_strobe", b_strobe, 1);
      chk("min_sel", b_sel, i % 2);
      chk("min_wrap", b_wrap, (i % 2) == 1);
    end
    cyc(0, 0, 4'h0, 0, 0, 2'b11);
    cyc(0, 0, 4'h0, 0, 1, 2'b11);

    // sweep over channels 1,2; one-shot builds end here, a new start repeats it
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        cyc(i == 0, 0, 4'b0110);
        chk("os_sel", a_sel, os_sel[i]);
      end
      cyc(0, 0, 4'b0110);
      cyc(0, 1, 4'b0110);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
